// File: rtl/uart_memif_bridge_if.sv
// scarv_ccx_memif: word-wide request/grant memory bus between an initiator and a responder.
// rdata/error are valid in the cycle after a req && gnt acceptance.
interface scarv_ccx_memif;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport REQ (output req, wen, strb, addr, wdata, input gnt, rdata, error);
  modport RSP (input req, wen, strb, addr, wdata, output gnt, rdata, error);
endinterface

// File: rtl/uart_memif_bridge.sv
// uart_memif_bridge: decodes UART read/write packets into memif accesses; req one cycle after the last byte, held until gnt.
// Response bytes wait on tx_busy. Optional inter-byte timeout: define UART_BRIDGE_TIMEOUT_EN.
module uart_memif_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  output logic        g_clk_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  scarv_ccx_memif.REQ memif
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_RSP, S_TX_STAT, S_TX_WAIT, S_TX_DATA
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        is_rd, is_rd_nxt;
  logic        ack, ack_nxt;
  logic        data_ph, data_ph_nxt;
  logic        req_q, req_nxt;
  logic        wen_q, wen_nxt;
  logic [3:0]  strb_q, strb_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        timeout;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Counts only while a packet is being assembled; any byte restarts it.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || rx_valid || !(state == S_ADDR || state == S_DATA)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout = (state == S_ADDR || state == S_DATA) && !rx_valid &&
                   (idle_cnt >= TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      is_rd   <= 1'b0;
      ack     <= 1'b0;
      data_ph <= 1'b0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      strb_q  <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      is_rd   <= is_rd_nxt;
      ack     <= ack_nxt;
      data_ph <= data_ph_nxt;
      req_q   <= req_nxt;
      wen_q   <= wen_nxt;
      strb_q  <= strb_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    is_rd_nxt   = is_rd;
    ack_nxt     = ack;
    data_ph_nxt = data_ph;
    req_nxt     = req_q;
    wen_nxt     = wen_q;
    strb_nxt    = strb_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    case (state)
      S_IDLE: begin
        cnt_nxt     = 2'd0;
        data_ph_nxt = 1'b0;
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_rd_nxt = (rx_data == CMD_RD);
            state_nxt = S_ADDR;
          end else begin
            ack_nxt   = 1'b0;
            state_nxt = S_TX_STAT;
          end
        end
      end
      S_ADDR: begin
        if (rx_break || timeout) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 2'd0;
        end else if (rx_valid) begin
          addr_nxt[{cnt, 3'b000} +: 8] = rx_data;
          addr_nxt[1:0] = 2'b00;
          cnt_nxt       = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_rd) begin
              state_nxt = S_REQ;
              req_nxt   = 1'b1;
              wen_nxt   = 1'b0;
              strb_nxt  = 4'hF;
            end else begin
              state_nxt = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_break || timeout) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 2'd0;
        end else if (rx_valid) begin
          wdata_nxt[{cnt, 3'b000} +: 8] = rx_data;
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = S_REQ;
            req_nxt   = 1'b1;
            wen_nxt   = 1'b1;
            strb_nxt  = 4'hF;
          end
        end
      end
      S_REQ: begin
        if (memif.gnt) begin
          req_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        ack_nxt   = !memif.error;
        rdata_nxt = memif.rdata;
        state_nxt = S_TX_STAT;
      end
      S_TX_STAT: begin
        if (!tx_busy) state_nxt = S_TX_WAIT;
      end
      // Guard cycle: the transmitter may not have raised tx_busy yet.
      S_TX_WAIT: begin
        if (data_ph) begin
          if (cnt == 2'd3) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt   = cnt + 2'd1;
            state_nxt = S_TX_DATA;
          end
        end else if (ack && is_rd) begin
          data_ph_nxt = 1'b1;
          cnt_nxt     = 2'd0;
          state_nxt   = S_TX_DATA;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_TX_DATA: begin
        if (!tx_busy) state_nxt = S_TX_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == S_TX_STAT) begin
      tx_data = ack ? RSP_ACK : RSP_NAK;
    end else if (state == S_TX_DATA) begin
      tx_data = rdata_q[{cnt, 3'b000} +: 8];
    end
  end

  assign tx_en       = (state == S_TX_STAT || state == S_TX_DATA) && !tx_busy;
  assign g_clk_req   = (state != S_IDLE) || rx_valid;
  assign memif.req   = req_q;
  assign memif.wen   = wen_q;
  assign memif.strb  = strb_q;
  assign memif.addr  = addr_q;
  assign memif.wdata = wdata_q;

endmodule

// File: doc/uart_memif_bridge.md
# uart_memif_bridge

UART-driven memory-bus initiator for debug and program loading. It consumes the received byte stream from a UART receiver and decodes simple read/write command packets. It issues word accesses as requester on a `scarv_ccx_memif` port, and returns status and read data through a UART transmitter byte interface. It sits between `uart_rx`/`uart_tx` instances and the interconnect, acting as the initiator counterpart of memory-mapped responders such as the UART peripheral.

## Interface
- `TIMEOUT_CYCLES`, default 500_000: inter-byte timeout in g_clk cycles. Used only with `UART_BRIDGE_TIMEOUT_EN`.
- `g_clk` input 1: clock.
- `g_resetn` input 1: reset; synchronous, active-low. Clock is g_clk.
- `g_clk_req` output 1: clock request.
- `rx_valid` input 1: one-cycle strobe; a received byte is on `rx_data`.
- `rx_data` input 8: received byte.
- `rx_break` input 1: BREAK detected by the receiver.
- `tx_busy` input 1: transmitter busy.
- `tx_en` output 1: one-cycle send strobe.
- `tx_data` output 8: byte to send.
- `memif` is a `scarv_ccx_memif.REQ` port, with signals `req`, `gnt`, `wen`, `strb[3:0]`, `addr[31:0]`, `wdata[31:0]`, `rdata[31:0]` and `error`.

## Operation
- Packet formats. All multi-byte fields are little-endian.
  - Write: `0x57`, then addr[4], then data[4].
  - Read: `0x52`, then addr[4].
- Address handling: `addr[1:0]` is forced to 0. `strb` is always 4'b1111.
- Responses:
  - Write OK: `0x06`.
  - Read OK: `0x06` followed by rdata[4], LSB first.
  - Bus error, on either read or write: `0x15` only.
  - Unknown command byte: `0x15` only; then return to IDLE.
- State machine (2-bit byte counter `cnt`):
  - IDLE: on `rx_valid`, latch the command. `0x52`/`0x57` go to ADDR with cnt=0; any other byte goes to TX_STAT with NAK.
  - ADDR: each `rx_valid` loads `addr[8*cnt+:8]`. At cnt=3, a read goes to REQ and a write goes to DATA with cnt=0.
  - DATA: each `rx_valid` loads `wdata[8*cnt+:8]`. At cnt=3, go to REQ.
  - REQ: `req`=1; `wen`=1 for a write. Hold `addr`/`wdata`/`wen`/`strb` stable until `req && gnt`, then go to RSP.
  - RSP: the cycle after acceptance. Sample `memif.error` and capture `memif.rdata` into the shift register, then go to TX_STAT.
  - TX_STAT: wait for `!tx_busy`. Pulse `tx_en` with the status byte, then go to TX_WAIT.
  - TX_WAIT: one-cycle guard in which `tx_busy` is ignored. After it:
    - following a read ACK, go to TX_DATA, or to TX_DATA with the next cnt after a data byte;
    - otherwise go to IDLE.
  - TX_DATA: wait for `!tx_busy`, then pulse `tx_en` with `rdata[8*cnt+:8]`. Go to TX_WAIT; after cnt=3 the sequence ends in IDLE.
- `rx_valid` in REQ, RSP, TX_STAT, TX_WAIT or TX_DATA: the byte is dropped.
- `rx_break` in ADDR or DATA: abort to IDLE with no response. In every other state it is ignored. An issued bus request always completes.
- `g_clk_req` = (state != IDLE) || `rx_valid`.

## Timing
- Reset values: `memif.req`=0, `wen`=0, `strb`=0, `addr`=0, `wdata`=0, `tx_en`=0, `tx_data`=0, state IDLE, cnt=0.
- Request issue: the final packet byte arrives at cycle T, and `req` is high from T+1.
- Bus handshake: with `gnt`=1 at T+1, `req` drops at T+2 and RSP is at T+2. The first `tx_en` is at T+3 if `tx_busy`=0.
- Response capture: `rdata` and `error` are valid exactly one cycle after `req && gnt`.
- Strobes: `tx_en` is never high in two consecutive cycles and is never asserted while `tx_busy`=1 (outside the TX_WAIT guard). `tx_data` is stable for the `tx_en` cycle.
- Reset mid-operation: all outputs return to their reset values the next cycle, with no completion.

## Configuration
- `UART_BRIDGE_TIMEOUT_EN` defined:
  - a counter clears on every `rx_valid` and on every entry to ADDR;
  - in ADDR or DATA, `TIMEOUT_CYCLES` consecutive cycles without `rx_valid` abort to IDLE with no response.
- `UART_BRIDGE_TIMEOUT_EN` undefined: there is no counter, and partial packets wait indefinitely.

## Test plan
- Write with immediate grant:
  - stimulus: bytes 57 00 10 00 20 EF BE AD DE, `gnt`=1;
  - response: one `req` cycle with `addr`=0x20001000, `wdata`=0xDEADBEEF, `wen`=1, `strb`=F; then `tx_data` 0x06.
- Read with stalled grant:
  - stimulus: bytes 52 03 00 00 00, `gnt` low for 3 cycles, `rdata`=0x12345678;
  - response: `req` held 4 cycles with stable `addr`=0x00000000; then tx bytes 06 78 56 34 12.
- Bus error on write:
  - stimulus: `error`=1 in the RSP cycle;
  - response: single tx byte 0x15, then back to IDLE.
- Unknown command:
  - stimulus: byte 0x41;
  - response: tx 0x15 and no `req`. A following valid read completes normally.
- Back-pressure:
  - stimulus: `tx_busy` held high for 100 cycles during the read response;
  - response: no `tx_en` while busy, and all 5 bytes are sent in order.
- Abort and timeout:
  - `rx_break` after 2 address bytes: no `req` and no tx; the next packet decodes correctly.
  - With `UART_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50: a stall of 50 cycles after 3 bytes aborts to IDLE.
